btn_debounce: RTL
=================

Name: btn_debounce

Overview:
- Conditions the five raw board push-button pins before button encoding: 2-FF synchroniser, per-button counter debounce, and one-cycle press, release and auto-repeat event pulses.
- Sits between the board button pins and the button encoder, which consumes its clean levels and action pulses.
- A held direction button produces a steady, rate-limited stream of move events.
- One `any_press_o` pulse serves the game-control start/restart handshake.

Parameters:
- BTN_NUM, 5: number of button channels. Bit order {c,r,l,d,u}, bit 0 = up.
- DEBOUNCE_CYC, 20: consecutive cycles of disagreement required before the debounced level changes. Must be >= 2.
- REPEAT_DELAY, 30: cycles from the press pulse to the first auto-repeat pulse. Must be >= 2.
- REPEAT_PERIOD, 6: cycles between subsequent auto-repeat pulses. Must be >= 2.

Ports:
- clk_run  input  1  game-logic clock; every register is clocked on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- en_i  input  1  1 = event pulses enabled. 0 = all pulses forced to 0 and repeat FSMs held in IDLE; level tracking continues.
- btn_pin_i  input  BTN_NUM  raw asynchronous pin levels, 1 = pressed.
- btn_level_o  output  BTN_NUM  debounced level per button.
- btn_press_o  output  BTN_NUM  one-cycle pulse on a debounced rising edge.
- btn_release_o  output  BTN_NUM  one-cycle pulse on a debounced falling edge.
- btn_act_o  output  BTN_NUM  btn_press_o OR auto-repeat pulse, per button.
- any_press_o  output  1  registered OR-reduction of btn_press_o, delayed one cycle.

Behaviour:
- Reset: all synchroniser flops, debounced levels, counters and outputs go to 0; FSMs go to IDLE.
  - A pin held high through reset produces a press pulse 2+DEBOUNCE_CYC cycles after rst deasserts.
- Synchroniser: s1 <= pin; s2 <= s1. Nothing downstream reads s1 or the pin directly.
- Debounce, per channel, with stable register db and counter cnt of width $clog2(DEBOUNCE_CYC):
  - s2 == db: cnt <= 0.
  - s2 != db and cnt == DEBOUNCE_CYC-1: db <= s2, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - Any bounce back to db restarts the count.
  - Latency from pin edge to btn_level_o = 2+DEBOUNCE_CYC cycles.
- Edge pulses:
  - btn_press_o / btn_release_o are registered and high for exactly the one cycle in which btn_level_o first shows the new value.
  - Both are gated by en_i.
- Repeat FSM per channel, counter rcnt of width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)):
  - IDLE: on db rising with en_i=1 -> HOLD, rcnt <= 0.
  - HOLD: rcnt++; when rcnt == REPEAT_DELAY-1 -> emit repeat pulse, go to RPT, rcnt <= 0.
  - RPT: rcnt++; when rcnt == REPEAT_PERIOD-1 -> emit repeat pulse, rcnt <= 0.
  - From any state: db falling, or en_i=0, or rst -> IDLE, rcnt <= 0, with no pulse in that cycle.
  - Release in the same cycle as a due repeat: release wins and no repeat pulse is emitted.
- btn_act_o: registered with the same timing as btn_press_o; press and repeat never coincide.
- Channels are fully independent.
  - Simultaneous presses produce simultaneous pulses.
  - any_press_o is asserted once for coincident presses.
- en_i rising while a button is already held: no press pulse and no repeat; the button must be released and re-pressed.

Decomposition:
- Shared define header: BTN_NUM value and the bit indices BTN_U/D/L/R/C, so the encoder indexes buttons by name.
- Timing defaults live in the header as `BTN_DEBOUNCE_CYC, `BTN_REPEAT_DELAY, `BTN_REPEAT_PERIOD.
- One sub-module, btn_debounce_ch: the single-channel synchroniser, debounce and repeat FSM. It is instantiated BTN_NUM times by a generate loop.
- The top level adds only the any_press_o register.

Test Plan (all scenarios use DEBOUNCE_CYC=4, REPEAT_DELAY=8, REPEAT_PERIOD=3, en_i=1):
- Clean press: pin[0] rises before edge 0 and stays high -> btn_level_o[0] and btn_press_o[0] go high after edge 5; btn_press_o[0] low after edge 6; any_press_o high for edges 6-7 only.
- Glitch rejection: pin[1] high for 3 cycles then low -> btn_level_o stays 0 and no pulses. Pin toggling every 2 cycles for 40 cycles -> no pulses.
- Auto-repeat: pin[2] held 30 cycles after press -> btn_act_o[2] pulses at press+0, +8, +11, +14, +17, +20, +23.
- Release:
  - Release mid-RPT -> btn_release_o pulses 6 cycles after the pin falls (2 sync + 4 debounce), and no further act pulses.
  - Release timed to coincide with a due repeat -> no repeat pulse is emitted.
- Reset mid-operation: rst for 1 cycle during RPT with the pin still high -> all outputs 0 next cycle; fresh press pulse 6 cycles after rst deasserts.
- en_i gating: en_i=0 while pin[4] pressed -> level follows and no pulses. Raise en_i while still held -> no pulses until release and re-press.

Source files
------------

// File: rtl/btn_debounce_pkg.sv
// ---------------------------------------------------------------------------
// btn_debounce_pkg
//
// Shared definitions for the push-button conditioning path.
//
// The macros are visible to every file compiled after this one, so the
// button encoder can index buttons by name (`BTN_U, `BTN_C, ...) and pick up
// the board-level timing defaults without importing anything.
//
// The package carries the same values as typed localparams, the repeat FSM
// state type, and two small constant helpers used to size the counters.
//
// No ports (package).
// ---------------------------------------------------------------------------

`ifndef BTN_DEBOUNCE_DEFS
`define BTN_DEBOUNCE_DEFS

// Number of button channels, bit order {c,r,l,d,u}.
`define BTN_NUM           5

// Bit index of each button inside the button vectors.
`define BTN_U             0
`define BTN_D             1
`define BTN_L             2
`define BTN_R             3
`define BTN_C             4

// Timing defaults in clk_run cycles.
`define BTN_DEBOUNCE_CYC  20
`define BTN_REPEAT_DELAY  30
`define BTN_REPEAT_PERIOD 6

`endif

package btn_debounce_pkg;

  // Typed copies of the header values, used as parameter defaults.
  localparam int BTN_NUM_DEF       = `BTN_NUM;
  localparam int DEBOUNCE_CYC_DEF  = `BTN_DEBOUNCE_CYC;
  localparam int REPEAT_DELAY_DEF  = `BTN_REPEAT_DELAY;
  localparam int REPEAT_PERIOD_DEF = `BTN_REPEAT_PERIOD;

  // Button bit positions, mirrored from the header for code that imports
  // the package instead of using the macros.
  localparam int BTN_U_IDX = `BTN_U;
  localparam int BTN_D_IDX = `BTN_D;
  localparam int BTN_L_IDX = `BTN_L;
  localparam int BTN_R_IDX = `BTN_R;
  localparam int BTN_C_IDX = `BTN_C;

  // Auto-repeat state per channel:
  //   RPT_IDLE - no repeat activity (button up, disabled, or held since
  //              before the enable came up)
  //   RPT_HOLD - waiting out the initial delay after the press pulse
  //   RPT_RUN  - emitting periodic repeat pulses
  typedef enum logic [1:0] {
    RPT_IDLE = 2'd0,
    RPT_HOLD = 2'd1,
    RPT_RUN  = 2'd2
  } rptState_e;

  // Larger of two integers, used to size the shared repeat counter.
  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cntWidth(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// ---------------------------------------------------------------------------
// btn_debounce_ch
//
// One button channel: 2-FF synchroniser, counter debounce and the
// auto-repeat FSM, plus the registered press / release / action pulses.
//
// Ports:
//   clk_run    in   game-logic clock, all flops on its rising edge
//   rst        in   synchronous active-high reset
//   en_i       in   1 = pulses enabled; 0 = pulses off, repeat FSM idle
//   pin_i      in   raw asynchronous pin level, 1 = pressed
//   level_o    out  debounced level
//   press_o    out  one-cycle pulse when level_o first shows 1
//   release_o  out  one-cycle pulse when level_o first shows 0
//   act_o      out  press pulse OR auto-repeat pulse
// ---------------------------------------------------------------------------

module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = DEBOUNCE_CYC_DEF,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic clk_run,
  input  logic rst,
  input  logic en_i,
  input  logic pin_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic act_o
);

  localparam int CNT_W  = cntWidth(DEBOUNCE_CYC);
  localparam int RCNT_W = cntWidth(maxInt(REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

  logic              sync1_q;
  logic              sync2_q;

  logic              db_q;
  logic              db_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              riseEvt;
  logic              fallEvt;

  rptState_e         state_q;
  rptState_e         state_d;
  logic [RCNT_W-1:0] rcnt_q;
  logic [RCNT_W-1:0] rcnt_d;
  logic              rptEvt;

  logic              press_q;
  logic              press_d;
  logic              release_q;
  logic              release_d;
  logic              act_q;
  logic              act_d;

  // Two-flop synchroniser. The pin is asynchronous to clk_run, so only
  // sync2_q is allowed to feed any downstream logic; sync1_q may go
  // metastable and gets a full cycle to settle.
  always_ff @(posedge clk_run) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next-state. The counter only advances while the synchronised
  // pin disagrees with the stable level; a single agreeing sample (a bounce
  // back) clears it, so the level only moves after DEBOUNCE_CYC
  // consecutive disagreeing samples. The edge events are raised in the
  // same cycle the stable level is about to change, which lets the pulse
  // registers line up with the new level on the output.
  always_comb begin
    db_d    = db_q;
    cnt_d   = '0;
    riseEvt = 1'b0;
    fallEvt = 1'b0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d    = sync2_q;
        riseEvt = sync2_q;
        fallEvt = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_run) begin
    if (rst) begin
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  // Auto-repeat next-state. Leaving for IDLE on release or disable is
  // checked before anything else, so a release landing on the same cycle
  // as a due repeat suppresses that repeat. IDLE only arms on a debounced
  // rising edge seen while enabled, which is why raising en_i while the
  // button is already held produces nothing until a fresh press.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rptEvt  = 1'b0;
    if (!en_i || fallEvt) begin
      state_d = RPT_IDLE;
      rcnt_d  = '0;
    end else begin
      unique case (state_q)
        RPT_IDLE: begin
          rcnt_d = '0;
          if (riseEvt) begin
            state_d = RPT_HOLD;
          end
        end
        RPT_HOLD: begin
          if (rcnt_q == DELAY_LAST) begin
            rptEvt  = 1'b1;
            state_d = RPT_RUN;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + RCNT_W'(1);
          end
        end
        RPT_RUN: begin
          if (rcnt_q == PERIOD_LAST) begin
            rptEvt = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + RCNT_W'(1);
          end
        end
        default: begin
          state_d = RPT_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  // Repeat FSM state register.
  always_ff @(posedge clk_run) begin
    if (rst) begin
      state_q <= RPT_IDLE;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Pulse next-state. A press needs the stable level to be low and a
  // repeat needs it high, so the two can never coincide in act.
  always_comb begin
    press_d   = en_i & riseEvt;
    release_d = en_i & fallEvt;
    act_d     = press_d | rptEvt;
  end

  // Pulse registers, updated on the same edge as the debounced level.
  always_ff @(posedge clk_run) begin
    if (rst) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      act_q     <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      act_q     <= act_d;
    end
  end

  assign level_o   = db_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign act_o     = act_q;

endmodule

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//
// Conditions the raw board push-buttons for the button encoder. Each pin
// gets its own independent btn_debounce_ch; this level only adds the
// registered any_press_o used by the game-control start/restart handshake.
//
// Ports:
//   clk_run        in   game-logic clock
//   rst            in   synchronous active-high reset
//   en_i           in   1 = event pulses enabled
//   btn_pin_i      in   [BTN_NUM] raw asynchronous pins, 1 = pressed
//   btn_level_o    out  [BTN_NUM] debounced levels
//   btn_press_o    out  [BTN_NUM] one-cycle press pulses
//   btn_release_o  out  [BTN_NUM] one-cycle release pulses
//   btn_act_o      out  [BTN_NUM] press or auto-repeat pulses
//   any_press_o    out  OR of btn_press_o, one cycle later
// ---------------------------------------------------------------------------

module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int BTN_NUM       = BTN_NUM_DEF,
  parameter int DEBOUNCE_CYC  = DEBOUNCE_CYC_DEF,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic               clk_run,
  input  logic               rst,
  input  logic               en_i,
  input  logic [BTN_NUM-1:0] btn_pin_i,
  output logic [BTN_NUM-1:0] btn_level_o,
  output logic [BTN_NUM-1:0] btn_press_o,
  output logic [BTN_NUM-1:0] btn_release_o,
  output logic [BTN_NUM-1:0] btn_act_o,
  output logic               any_press_o
);

  logic anyPress_q;
  logic anyPress_d;

  // One fully independent channel per button.
  for (genvar ch = 0; ch < BTN_NUM; ch++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYC  (DEBOUNCE_CYC),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .clk_run   (clk_run),
      .rst       (rst),
      .en_i      (en_i),
      .pin_i     (btn_pin_i[ch]),
      .level_o   (btn_level_o[ch]),
      .press_o   (btn_press_o[ch]),
      .release_o (btn_release_o[ch]),
      .act_o     (btn_act_o[ch])
    );
  end

  // Coincident presses on several buttons collapse into one pulse here,
  // so the start/restart handshake sees a single event.
  always_comb begin
    anyPress_d = |btn_press_o;
  end

  // any_press register, one cycle behind the press pulses.
  always_ff @(posedge clk_run) begin
    if (rst) begin
      anyPress_q <= 1'b0;
    end else begin
      anyPress_q <= anyPress_d;
    end
  end

  assign any_press_o = anyPress_q;

endmodule
